// File: rtl/u_xmit_arb_if.sv
// Requester/UART-side bundle for the transmit arbiter.
// The arbiter uses the slave modport; requesters and the UART side use master.
interface u_xmit_arb_if #(parameter int NUM_REQ = 4);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0][7:0] req_data;
  logic [NUM_REQ-1:0]      req_last;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    xmitH;
  logic [7:0]              xmit_dataH;
  logic                    xmit_doneH;
  logic [IW-1:0]           grant_id;
  logic                    busy;
  logic                    lock_err;

  modport master (
    output req_valid, req_data, req_last, xmit_doneH,
    input  req_ready, xmitH, xmit_dataH, grant_id, busy, lock_err
  );

  modport slave (
    input  req_valid, req_data, req_last, xmit_doneH,
    output req_ready, xmitH, xmit_dataH, grant_id, busy, lock_err
  );
endinterface

// File: rtl/u_xmit_arb.sv
// Round-robin byte scheduler in front of the UART transmitter: packet lock,
// one xmitH pulse per byte, pacing on xmit_doneH, optional inter-byte gap.
module u_xmit_arb #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 0,
  parameter int LOCK_TIMEOUT = 4096
) (
  input logic          sys_clk,
  input logic          sys_rst,
  u_xmit_arb_if.slave  bus
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_LO, WAIT_HI, GAP} state_t;

  state_t             state_q, state_d;
  logic               lock_q, lock_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      grant_q, grant_d;
  logic               last_q, last_d;
  logic [7:0]         data_q, data_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               xmit_q, xmit_d;
  logic               lerr_q, lerr_d;
  logic [15:0]        tmo_q, tmo_d;
  logic [15:0]        gap_q, gap_d;

  logic               found;
  logic [IW-1:0]      win, cand;

  // Walk the search order backwards so the nearest requester after rr_q wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    if (lock_q) begin
      found = bus.req_valid[grant_q];
      win   = grant_q;
    end else begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        cand = IW'((int'(rr_q) + k) % NUM_REQ);
        if (bus.req_valid[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    last_d  = last_q;
    data_d  = data_q;
    ready_d = '0;
    xmit_d  = 1'b0;
    lerr_d  = 1'b0;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (bus.xmit_doneH && found) begin
          data_d       = bus.req_data[win];
          ready_d[win] = 1'b1;
          xmit_d       = 1'b1;
          grant_d      = win;
          last_d       = bus.req_last[win];
          lock_d       = ~bus.req_last[win];
          tmo_d        = '0;
          state_d      = SEND;
        end else if (lock_q && !bus.req_valid[grant_q]) begin
          // Owner went quiet too long: release it and make it lowest priority.
          if (tmo_q == 16'(LOCK_TIMEOUT - 1)) begin
            lock_d = 1'b0;
            rr_d   = grant_q;
            lerr_d = 1'b1;
            tmo_d  = '0;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
      end
      SEND:    state_d = WAIT_LO;
      WAIT_LO: if (!bus.xmit_doneH) state_d = WAIT_HI;
      WAIT_HI: begin
        if (bus.xmit_doneH) begin
          if (last_q) rr_d = grant_q;
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_q == 16'(GAP_CYCLES - 1)) state_d = IDLE;
        else                              gap_d   = gap_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      lock_q  <= 1'b0;
      rr_q    <= IW'(NUM_REQ - 1);
      grant_q <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      ready_q <= '0;
      xmit_q  <= 1'b0;
      lerr_q  <= 1'b0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      xmit_q  <= xmit_d;
      lerr_q  <= lerr_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.xmitH      = xmit_q;
  assign bus.xmit_dataH = data_q;
  assign bus.grant_id   = grant_q;
  assign bus.busy       = (state_q != IDLE) || lock_q;
  assign bus.lock_err   = lerr_q;
endmodule

// File: tb/tb_u_xmit_arb.sv
// Random and directed stimulus for u_xmit_arb against a transaction-level
// arbitration model; a behavioural UART stand-in paces xmit_doneH.
module tb_u_xmit_arb;
  localparam int N = 4, GAP = 5, LTO = 8;
  localparam longint BIG = 64'd1 << 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  u_xmit_arb_if #(.NUM_REQ(N)) bus ();

  u_xmit_arb #(.NUM_REQ(N), .GAP_CYCLES(GAP), .LOCK_TIMEOUT(LTO)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // requester sources
  logic [7:0] qd [N][$];
  logic       ql [N][$];
  int         dly [N];
  logic [N-1:0] v_drv;
  bit         rnd;

  // arbitration model state
  longint     cyc, d_open;
  logic       m_lock, m_plast;
  int         m_rr, m_own, m_tmo, acc_w;
  logic [N-1:0] e_ready;
  logic       e_xmit, e_lerr;
  logic [7:0] e_data;
  int         e_grant;

  // UART stand-in and logs
  int         u_st, u_cnt;
  logic [7:0] obs[$];
  longint     x_edges[$], rise_edges[$];
  longint     lerr_edge;
  int         base_o, base_r, base_x;

  logic [7:0] exp_rr [5] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
  logic [7:0] exp_pk [5] = '{8'hA1, 8'hA2, 8'hA3, 8'h2C, 8'h0B};

  function automatic logic [31:0] obs_at(input int i);
    return (i < obs.size()) ? 32'(obs[i]) : 32'hDEAD;
  endfunction
  function automatic longint xe_at(input int i);
    return (i < x_edges.size()) ? x_edges[i] : -1;
  endfunction
  function automatic longint re_at(input int i);
    return (i < rise_edges.size()) ? rise_edges[i] : -1;
  endfunction

  task automatic model_reset();
    m_lock = 1'b0; m_plast = 1'b0; m_rr = N - 1; m_own = 0; m_tmo = 0;
    d_open = 0; e_ready = '0; e_xmit = 1'b0; e_lerr = 1'b0; e_data = 8'h00; e_grant = 0;
    acc_w = -1;
  endtask

  // One clock edge: who may be accepted, given what the requesters presented.
  task automatic model_step();
    e_ready = '0; e_xmit = 1'b0; e_lerr = 1'b0; acc_w = -1;
    if (rst) model_reset();
    else if (cyc >= d_open) begin
      if (m_lock) begin
        if (v_drv[m_own]) acc_w = m_own;
        else if (m_tmo == LTO - 1) begin
          m_lock = 1'b0; m_rr = m_own; m_tmo = 0; e_lerr = 1'b1;
        end else m_tmo++;
      end else begin
        for (int k = 1; k <= N; k++)
          if (acc_w < 0 && v_drv[(m_rr + k) % N]) acc_w = (m_rr + k) % N;
      end
      if (acc_w >= 0) begin
        e_ready[acc_w] = 1'b1; e_xmit = 1'b1; e_data = qd[acc_w][0]; e_grant = acc_w;
        m_own = acc_w; m_plast = ql[acc_w][0]; m_lock = !m_plast; m_tmo = 0; d_open = BIG;
      end
    end
  endtask

  task automatic uart_rise();
    rise_edges.push_back(cyc);
    if (!rst) begin
      d_open = cyc + GAP + 2;
      if (m_plast) m_rr = m_own;
    end
  endtask

  task automatic step_sources();
    for (int i = 0; i < N; i++) begin
      if (acc_w == i) begin
        void'(qd[i].pop_front()); void'(ql[i].pop_front());
        v_drv[i] = 1'b0;
        if (rnd) dly[i] = ($urandom_range(5, 0) == 0) ? int'($urandom_range(30, 10))
                                                      : int'($urandom_range(3, 0));
        else dly[i] = 0;
      end
      if (!v_drv[i] && qd[i].size() > 0) begin
        if (dly[i] == 0) v_drv[i] = 1'b1;
        else dly[i]--;
      end
      bus.req_data[i] = (qd[i].size() > 0) ? qd[i][0] : 8'h00;
      bus.req_last[i] = (ql[i].size() > 0) ? ql[i][0] : 1'b0;
    end
    bus.req_valid = v_drv;
  endtask

  task automatic run(input int nc);
    repeat (nc) begin
      @(posedge clk); #1; cyc++;
      model_step();
      chk("ready",    32'(bus.req_ready),  32'(e_ready));
      chk("xmitH",    32'(bus.xmitH),      32'(e_xmit));
      chk("data",     32'(bus.xmit_dataH), 32'(e_data));
      chk("grant",    32'(bus.grant_id),   32'(e_grant));
      chk("busy",     32'(bus.busy),       32'((cyc < d_open - 1) || m_lock));
      chk("lock_err", 32'(bus.lock_err),   32'(e_lerr));
      if (bus.xmitH) begin obs.push_back(bus.xmit_dataH); x_edges.push_back(cyc); end
      if (bus.lock_err && lerr_edge < 0) lerr_edge = cyc;
      case (u_st)
        0: if (bus.xmitH) begin u_st = 1; u_cnt = int'($urandom_range(2, 1)); end
        1: begin
          u_cnt--;
          if (u_cnt == 0) begin bus.xmit_doneH = 1'b0; u_st = 2; u_cnt = int'($urandom_range(6, 2)); end
        end
        default: begin
          u_cnt--;
          if (u_cnt == 0) begin bus.xmit_doneH = 1'b1; u_st = 0; uart_rise(); end
        end
      endcase
      step_sources();
    end
  endtask

  task automatic clr();
    for (int i = 0; i < N; i++) begin qd[i].delete(); ql[i].delete(); dly[i] = 0; end
    v_drv = '0;
    bus.req_valid = '0;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    qd[r].push_back(d); ql[r].push_back(l);
  endtask

  task automatic begin_test();
    rst = 1'b1; model_reset(); clr(); rnd = 1'b0;
    run(10);
  endtask

  task automatic release_rst();
    base_o = obs.size(); base_r = rise_edges.size(); base_x = x_edges.size();
    lerr_edge = -1;
    rst = 1'b0;
  endtask

  int pending;

  initial begin
    cyc = 0; u_st = 0; u_cnt = 0; lerr_edge = -1; rnd = 1'b0;
    bus.xmit_doneH = 1'b1; bus.req_data = '0; bus.req_last = '0;
    model_reset(); clr();

    // reset with every requester valid, then requester 0 goes first
    push(0, 8'h5A, 1'b1); push(1, 8'h6B, 1'b1); push(2, 8'h7C, 1'b1); push(3, 8'h8D, 1'b1);
    run(3);
    release_rst();
    run(60);
    chk("t1_first_byte", obs_at(base_o), 32'h5A);

    // round robin over single-byte packets, gap pacing between bytes
    begin_test();
    push(0, 8'h10, 1'b1); push(0, 8'h10, 1'b1);
    push(1, 8'h20, 1'b1); push(2, 8'h30, 1'b1); push(3, 8'h40, 1'b1);
    release_rst();
    run(200);
    for (int k = 0; k < 5; k++) chk("t2_rr_byte", obs_at(base_o + k), 32'(exp_rr[k]));
    chk("t2_pulse_count", 32'(obs.size() - base_o), 32'd5);
    for (int k = 1; k < 5; k++)
      chk("t2_gap", 32'(xe_at(base_x + k) - re_at(base_r + k - 1)), 32'(GAP + 2));

    // packet lock keeps req1's three bytes together
    begin_test();
    push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
    push(0, 8'h0B, 1'b1); push(2, 8'h2C, 1'b1);
    dly[0] = 3; dly[2] = 3;
    release_rst();
    run(200);
    for (int k = 0; k < 5; k++) chk("t3_pkt_byte", obs_at(base_o + k), 32'(exp_pk[k]));

    // abandoned packet: lock dropped by timeout, req3 served next
    begin_test();
    push(1, 8'h55, 1'b0); push(3, 8'h3D, 1'b1);
    dly[3] = 3;
    release_rst();
    run(80);
    chk("t4_first",    obs_at(base_o),     32'h55);
    chk("t4_next",     obs_at(base_o + 1), 32'h3D);
    chk("t4_lerr_at",  32'(lerr_edge), 32'(re_at(base_r) + GAP + LTO + 1));
    chk("t4_after_to", 32'(xe_at(base_x + 1)), 32'(lerr_edge + 1));

    // reset while the UART is mid-byte
    begin_test();
    push(0, 8'h01, 1'b1); push(0, 8'h02, 1'b1);
    push(1, 8'h11, 1'b1); push(2, 8'h21, 1'b1); push(3, 8'h31, 1'b1);
    release_rst();
    for (int t = 0; t < 40 && u_st != 2; t++) run(1);
    chk("t6_in_wait_lo", 32'(u_st), 32'd2);
    rst = 1'b1;
    #1;
    chk("t6_rst_xmitH", 32'(bus.xmitH),     32'd0);
    chk("t6_rst_ready", 32'(bus.req_ready), 32'd0);
    chk("t6_rst_busy",  32'(bus.busy),      32'd0);
    model_reset();
    run(10);
    release_rst();
    run(40);
    chk("t6_restart", obs_at(base_o), 32'h02);

    // randomized multi-byte packets with occasional owner stalls
    begin_test();
    rnd = 1'b1;
    for (int i = 0; i < N; i++) begin
      int np;
      np = int'($urandom_range(8, 4));
      for (int p = 0; p < np; p++) begin
        int len;
        len = int'($urandom_range(3, 1));
        for (int b = 0; b < len; b++) push(i, 8'($urandom), (b == len - 1));
      end
      dly[i] = int'($urandom_range(5, 0));
    end
    release_rst();
    run(4000);
    pending = 0;
    for (int i = 0; i < N; i++) pending += qd[i].size();
    chk("rand_drained", 32'(pending), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
